// File: rtl/aes_128_dec_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_128_dec_iter
// Brief    : Iterative AES-128 inverse cipher, one inverse round per clock,
//            with the key schedule run backward from a cached or expanded rk10.
// Revision : 1.0
// ============================================================================
module aes_128_dec_iter #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEXP  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [0:255][7:0] c_sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] x);
        return x[0] ? ({1'b0, x[7:1]} ^ 8'h8d) : {1'b0, x[7:1]};
    endfunction

    // Returns {9*a, 11*a, 13*a, 14*a} in GF(2^8).
    function automatic logic [31:0] mul_9bde(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return {x8 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ x4 ^ x2};
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [31:0] m0, m1, m2, m3;
        m0 = mul_9bde(col[31:24]);
        m1 = mul_9bde(col[23:16]);
        m2 = mul_9bde(col[15:8]);
        m3 = mul_9bde(col[7:0]);
        return {m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24],
                m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8],
                m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16],
                m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0]};
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {c_sbox[w[23:16]], c_sbox[w[15:8]], c_sbox[w[7:0]], c_sbox[w[31:24]]};
    endfunction

    state_t       r_state, w_state_nxt;
    logic [127:0] r_rk, r_s, r_ct, r_key, r_pt;
    logic [7:0]   r_rcon;
    logic [3:0]   r_cnt;
    logic         r_out_valid;
    logic         w_last, w_hit;
    logic [127:0] w_cache_rk, w_isb, w_ark, w_imc, w_rk_next, w_rk_prev;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_w3p, w_sr_in, w_sr_out;
    logic [31:0]  w_n0, w_n1, w_n2;

    assign w_last    = (r_cnt == 4'd9);
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign busy      = (r_state == ST_KEXP) || (r_state == ST_ROUND);
    assign out_valid = r_out_valid;
    assign pt        = r_pt;

    // One set of four S-boxes serves both the forward and the backward key step.
    assign {w_w0, w_w1, w_w2, w_w3} = r_rk;
    assign w_w3p    = w_w3 ^ w_w2;
    assign w_sr_in  = (r_state == ST_KEXP) ? w_w3 : w_w3p;
    assign w_sr_out = sub_rot(w_sr_in) ^ {r_rcon, 24'h0};

    assign w_n0      = w_w0 ^ w_sr_out;
    assign w_n1      = w_w1 ^ w_n0;
    assign w_n2      = w_w2 ^ w_n1;
    assign w_rk_next = {w_n0, w_n1, w_n2, w_w3 ^ w_n2};
    assign w_rk_prev = {w_w0 ^ w_sr_out, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3p};

    for (genvar i = 0; i < 16; i++) begin : g_isb
        localparam int c_src = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
        assign w_isb[127-8*i -: 8] = c_inv_sbox[r_s[127-8*c_src -: 8]];
    end

    assign w_ark = w_isb ^ w_rk_prev;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign w_imc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
    end

    if (KEY_CACHE != 0) begin : g_cache
        logic [127:0] r_cache_key, r_cache_rk;
        logic         r_cache_valid;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cache_valid <= 1'b0;
                r_cache_key   <= '0;
                r_cache_rk    <= '0;
            end else if (r_state == ST_KEXP && w_last) begin
                r_cache_valid <= 1'b1;
                r_cache_key   <= r_key;
                r_cache_rk    <= w_rk_next;
            end
        end

        assign w_hit      = r_cache_valid && (key == r_cache_key);
        assign w_cache_rk = r_cache_rk;
    end else begin : g_no_cache
        assign w_hit      = 1'b0;
        assign w_cache_rk = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)  w_state_nxt = w_hit ? ST_ROUND : ST_KEXP;
            ST_KEXP:  if (w_last)    w_state_nxt = ST_ROUND;
            ST_ROUND: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rk        <= '0;
            r_s         <= '0;
            r_ct        <= '0;
            r_key       <= '0;
            r_pt        <= '0;
            r_rcon      <= 8'h00;
            r_cnt       <= 4'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_ct  <= ct;
                        r_key <= key;
                        r_cnt <= 4'd0;
                        if (w_hit) begin
                            r_rk   <= w_cache_rk;
                            r_s    <= ct ^ w_cache_rk;
                            r_rcon <= 8'h36;
                        end else begin
                            r_rk   <= key;
                            r_rcon <= 8'h01;
                        end
                    end
                end
                ST_KEXP: begin
                    r_rk <= w_rk_next;
                    if (w_last) begin
                        r_s    <= r_ct ^ w_rk_next;
                        r_rcon <= 8'h36;
                        r_cnt  <= 4'd0;
                    end else begin
                        r_rcon <= xtime(r_rcon);
                        r_cnt  <= r_cnt + 4'd1;
                    end
                end
                ST_ROUND: begin
                    r_rk   <= w_rk_prev;
                    r_rcon <= inv_xtime(r_rcon);
                    if (w_last) begin
                        r_s         <= w_ark;
                        r_pt        <= w_ark;
                        r_out_valid <= 1'b1;
                        r_cnt       <= 4'd0;
                    end else begin
                        r_s   <= w_imc;
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_128_dec_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_128_dec_iter
// Brief    : Scoreboard bench; expected plaintexts come from a forward AES model.
// Revision : 1.0
// ============================================================================
module tb_aes_128_dec_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] ct = '0;
    logic [127:0] key = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] pt;

    aes_128_dec_iter #(.KEY_CACHE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ct(ct), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .pt(pt), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        logic [127:0] pt;
        int           acc;
        int           lat;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    int           ready_mode = 0;
    logic         m_valid = 1'b0;
    logic [127:0] m_key = '0;
    logic [7:0]   sb [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] x, inv;
        for (int v = 0; v < 256; v++) begin
            x   = v[7:0];
            inv = 8'h00;
            if (x != 8'h00) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, x);
            end
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  tmp;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) st[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[st[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) st[rr+4*c] = t[rr + 4*((c+rr)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    st[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    // Drives one block; the expectation is queued once in_ready guarantees acceptance.
    task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                        output int acc);
        int  n;
        logic hit;
        @(posedge clk); #1;
        key = k; ct = c; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            acc = -1;
        end else begin
            hit     = m_valid && (m_key == k);
            m_key   = k;
            m_valid = 1'b1;
            acc     = cyc + 1;
            q.push_back('{pt: p, acc: cyc + 1, lat: (hit ? 10 : 20)});
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !in_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || !in_ready) chk("drain_timeout", 128'(q.size()), 128'(0));
    endtask

    initial begin
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    logic         mon_seen = 1'b0;
    logic [127:0] mon_held = '0;
    int           mon_busy = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_seen = 1'b0;
            mon_busy = 0;
        end else begin
            if (busy) mon_busy++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 128'(out_valid), 128'(0));
                end else if (!mon_seen) begin
                    mon_seen = 1'b1;
                    mon_held = pt;
                    chk("latency", 128'(cyc - q[0].acc), 128'(q[0].lat));
                    chk("busy_cycles", 128'(mon_busy), 128'(q[0].lat));
                end else begin
                    chk("pt_hold", pt, mon_held);
                end
                if (out_ready && q.size() != 0) begin
                    chk("pt", pt, q[0].pt);
                    void'(q.pop_front());
                    mon_seen = 1'b0;
                    mon_busy = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           acc, n, t_rst;
        logic [127:0] rk, rp, prev_k;
        build_sbox();

        @(negedge clk); @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_pt", pt, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 128'(in_ready), 128'(1));

        send(C1_KEY, C1_CT, C1_PT, acc);
        wait_drain();

        send(B_KEY, B_CT, B_PT, acc);
        while (cyc < acc + 10) @(negedge clk);
        chk("rk10_after_kexp", dut.r_rk, B_RK10);
        wait_drain();

        // Consumer stalls with in_valid pulses that must be ignored.
        ready_mode = 2;
        send(C1_KEY, C1_CT, C1_PT, acc);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 128'(out_valid), 128'(1));
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            in_valid = (k % 2 == 0);
            ct  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 128'(in_ready), 128'(1));
        chk("bp_release_busy", 128'(busy), 128'(0));
        chk("bp_release_out_valid", 128'(out_valid), 128'(0));
        chk("bp_pt_kept", pt, C1_PT);
        wait_drain();

        send(B_KEY, B_CT, B_PT, acc);
        send(C1_KEY, C1_CT, C1_PT, acc);
        send(C1_KEY, C1_CT, C1_PT, acc);
        wait_drain();

        // Reset at ROUND cnt=4 must abort and invalidate the cache.
        send(B_KEY, B_CT, B_PT, acc);
        t_rst = acc + ((q[q.size()-1].lat == 20) ? 14 : 4);
        while (cyc < t_rst) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        q.delete();
        m_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        chk("abort_pt", pt, 128'(0));
        repeat (30) @(negedge clk);
        send(B_KEY, B_CT, B_PT, acc);
        wait_drain();

        ready_mode = 1;
        prev_k = C1_KEY;
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 2) == 0) rk = prev_k;
            else rk = {$urandom, $urandom, $urandom, $urandom};
            rp = {$urandom, $urandom, $urandom, $urandom};
            prev_k = rk;
            send(rk, aes_enc(rk, rp), rp, acc);
        end
        wait_drain();
        ready_mode = 0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
